// File: rtl/if_id_queue_if.sv
// Fetch/decode handshake bundle for the IF/ID prefetch queue.
interface if_id_queue_if #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic             flush;
  logic             in_valid;
  logic [WIDTH-1:0] PC_in;
  logic [WIDTH-1:0] Instruction_in;
  logic             freeze;
  logic             out_valid;
  logic [WIDTH-1:0] PC_out;
  logic [WIDTH-1:0] Instruction_out;
  logic             if_stall;
  logic [CW-1:0]    count;

  // Pipeline side: drives fetch data and control, observes the head entry.
  modport master (
    output flush, in_valid, PC_in, Instruction_in, freeze,
    input  out_valid, PC_out, Instruction_out, if_stall, count
  );

  // Queue side.
  modport slave (
    input  flush, in_valid, PC_in, Instruction_in, freeze,
    output out_valid, PC_out, Instruction_out, if_stall, count
  );
endinterface

// File: rtl/if_id_queue.sv
// Instruction prefetch queue between fetch and decode: first-word-fall-through
// FIFO of {PC, Instruction} pairs, cleared by a taken branch.
module if_id_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input logic          clk,
  input logic          rst,
  if_id_queue_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef struct packed {
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] ins;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_c, empty_c, push_c, pop_c;
  entry_t        head_c;

  // Occupancy flags and the handshake qualifiers; flush overrides both moves.
  always_comb begin
    full_c  = (count_q == CW'(DEPTH));
    empty_c = (count_q == '0);
    push_c  = bus.in_valid & ~full_c & ~bus.flush;
    pop_c   = ~empty_c & ~bus.freeze & ~bus.flush;
  end

  // Next pointer/occupancy state; power-of-two depth makes pointer wrap free.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_c) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_c)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_c, pop_c})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents need no reset because occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr_q] <= '{pc: bus.PC_in, ins: bus.Instruction_in};
  end

  // Head entry, forced to a zero bubble while empty.
  always_comb begin
    head_c = '0;
    if (!empty_c) head_c = mem[rd_ptr_q];
  end

  assign bus.out_valid       = ~empty_c;
  assign bus.PC_out          = head_c.pc;
  assign bus.Instruction_out = head_c.ins;
  assign bus.if_stall        = full_c;
  assign bus.count           = count_q;

  // Occupancy stays in range and agrees with the pointer distance.
  a_count_range: assert property (@(posedge clk) disable iff (!rst)
    count_q <= CW'(DEPTH));
  a_count_ptrs: assert property (@(posedge clk) disable iff (!rst)
    count_q[AW-1:0] == AW'(wr_ptr_q - rd_ptr_q));
endmodule
